// File: rtl/sysbus_arb_pkg.sv
// -----------------------------------------------------------------------------
// sysbus_arb_pkg
// Shared types and default constants for the system-bus arbiter slice.
//   sysbus_state_t      : arbiter FSM state (IDLE, BUSY, RESP)
//   SYSBUS_NUM_MASTERS  : default number of requesting masters
//   SYSBUS_ADDR_W       : default bus address width
//   SYSBUS_DATA_W       : default bus data width
//   SYSBUS_TIMEOUT_CYC  : default slave-ack timeout in cycles
//   sysbus_idx_w()      : width of a master index for a given master count
// -----------------------------------------------------------------------------
package sysbus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } sysbus_state_t;

  localparam int SYSBUS_NUM_MASTERS = 4;
  localparam int SYSBUS_ADDR_W      = 24;
  localparam int SYSBUS_DATA_W      = 16;
  localparam int SYSBUS_TIMEOUT_CYC = 255;

  // A single-master index still needs one bit to be a legal vector.
  function automatic int sysbus_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sysbus_arb_if.sv
// -----------------------------------------------------------------------------
// sysbus_arb_if
// Bundle of the master-side and slave-side bus signals around the arbiter.
//   Master side : m_req, m_we, m_addr, m_wdata (to arbiter)
//                 m_gnt, m_rvalid, m_rdata, m_err (from arbiter)
//   Slave side  : s_req, s_we, s_addr, s_wdata (from arbiter)
//                 s_ack, s_rdata (to arbiter)
//   Status      : busy (from arbiter)
// Modports:
//   slave  - the arbiter's view (it serves the requesting masters)
//   master - the surrounding system's view (requesters + downstream slave)
// -----------------------------------------------------------------------------
interface sysbus_arb_if
  import sysbus_arb_pkg::*;
#(
  parameter int NUM_MASTERS = SYSBUS_NUM_MASTERS,
  parameter int ADDR_W      = SYSBUS_ADDR_W,
  parameter int DATA_W      = SYSBUS_DATA_W
);

  logic [NUM_MASTERS-1:0]             m_req;
  logic [NUM_MASTERS-1:0]             m_we;
  logic [NUM_MASTERS-1:0][ADDR_W-1:0] m_addr;
  logic [NUM_MASTERS-1:0][DATA_W-1:0] m_wdata;
  logic [NUM_MASTERS-1:0]             m_gnt;
  logic [NUM_MASTERS-1:0]             m_rvalid;
  logic [DATA_W-1:0]                  m_rdata;
  logic                               m_err;

  logic                               s_req;
  logic                               s_we;
  logic [ADDR_W-1:0]                  s_addr;
  logic [DATA_W-1:0]                  s_wdata;
  logic                               s_ack;
  logic [DATA_W-1:0]                  s_rdata;

  logic                               busy;

  modport slave (
    input  m_req, m_we, m_addr, m_wdata, s_ack, s_rdata,
    output m_gnt, m_rvalid, m_rdata, m_err, s_req, s_we, s_addr, s_wdata, busy
  );

  modport master (
    output m_req, m_we, m_addr, m_wdata, s_ack, s_rdata,
    input  m_gnt, m_rvalid, m_rdata, m_err, s_req, s_we, s_addr, s_wdata, busy
  );

endinterface

// File: rtl/sysbus_rr_pick.sv
// -----------------------------------------------------------------------------
// sysbus_rr_pick
// Combinational round-robin selector. Starting at i_ptr+1 and wrapping at
// NUM_MASTERS, returns the first requesting master.
//   i_req     in  NUM_MASTERS  request vector
//   i_ptr     in  IDX_W        index of the last served master
//   o_onehot  out NUM_MASTERS  one-hot winner (0 when no request)
//   o_idx     out IDX_W        winner index (0 when no request)
//   o_valid   out 1            at least one request present
// -----------------------------------------------------------------------------
module sysbus_rr_pick
  import sysbus_arb_pkg::*;
#(
  parameter int NUM_MASTERS = SYSBUS_NUM_MASTERS,
  localparam int IDX_W      = sysbus_idx_w(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic [IDX_W-1:0]       i_ptr,
  output logic [NUM_MASTERS-1:0] o_onehot,
  output logic [IDX_W-1:0]       o_idx,
  output logic                   o_valid
);

  logic [IDX_W-1:0] w_cand;

  // NOTE: every output of a combinational block gets a default before any
  // branch; a path that leaves one unassigned would infer a latch.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    w_cand   = '0;
    // ptr itself is visited last, so the master just served has lowest priority.
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      w_cand = IDX_W'((int'(i_ptr) + k) % NUM_MASTERS);
      if (!o_valid && i_req[w_cand]) begin
        o_valid          = 1'b1;
        o_idx            = w_cand;
        o_onehot[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sysbus_arb.sv
// -----------------------------------------------------------------------------
// sysbus_arb
// Round-robin arbiter placing one master transaction at a time onto a single
// downstream slave. IDLE picks a winner and latches its payload, BUSY drives
// the slave until s_ack, RESP returns the completion pulse to the winner.
//   clk1_50  in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   bus      if   sysbus_arb_if.slave: master request/grant/response signals,
//                 downstream request/ack signals, busy status
// Optional feature (macro SYSBUS_TIMEOUT_EN): a BUSY cycle counter aborts a
// transaction after TIMEOUT_CYC cycles without s_ack, completing it with
// m_err=1 and m_rdata=0. Without the macro BUSY waits forever, m_err is 0.
// -----------------------------------------------------------------------------
module sysbus_arb
  import sysbus_arb_pkg::*;
#(
  parameter int NUM_MASTERS = SYSBUS_NUM_MASTERS,
  parameter int ADDR_W      = SYSBUS_ADDR_W,
  parameter int DATA_W      = SYSBUS_DATA_W,
  parameter int TIMEOUT_CYC = SYSBUS_TIMEOUT_CYC
) (
  input  logic        clk1_50,
  input  logic        rst,
  sysbus_arb_if.slave bus
);

  localparam int IDX_W = sysbus_idx_w(NUM_MASTERS);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535)
  begin : g_param_check
    $error("sysbus_arb: NUM_MASTERS or TIMEOUT_CYC out of range");
  end

  sysbus_state_t          r_state;
  sysbus_state_t          w_state_nxt;

  logic [IDX_W-1:0]       r_ptr;
  logic [IDX_W-1:0]       r_win_idx;
  logic [NUM_MASTERS-1:0] r_win_oh;
  logic [NUM_MASTERS-1:0] r_gnt;
  logic                   r_we;
  logic [ADDR_W-1:0]      r_addr;
  logic [DATA_W-1:0]      r_wdata;
  logic [DATA_W-1:0]      r_rdata;

  logic [NUM_MASTERS-1:0] w_pick_oh;
  logic [IDX_W-1:0]       w_pick_idx;
  logic                   w_pick_valid;
  logic                   w_ack;
  logic                   w_timeout;

  sysbus_rr_pick #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_pick (
    .i_req    (bus.m_req),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_oh),
    .o_idx    (w_pick_idx),
    .o_valid  (w_pick_valid)
  );

  // s_ack only means something while a transaction is on the slave bus.
  assign w_ack = (r_state == BUSY) && bus.s_ack;

`ifdef SYSBUS_TIMEOUT_EN
  localparam int CNT_W = 16;

  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  // Fires in the TIMEOUT_CYC-th BUSY cycle; a same-cycle ack takes priority.
  assign w_timeout = (r_state == BUSY) && !bus.s_ack &&
                     (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk1_50 or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state != BUSY) begin
        r_cnt <= '0;
      end else if (!bus.s_ack) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_ack) begin
        r_err <= 1'b0;
      end else if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.m_err = r_err;
`else
  assign w_timeout = 1'b0;
  assign bus.m_err = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk1_50 or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_pick_valid)        w_state_nxt = BUSY;
      BUSY:    if (w_ack || w_timeout)  w_state_nxt = RESP;
      RESP:                             w_state_nxt = IDLE;
      default:                          w_state_nxt = IDLE;
    endcase
  end

  // NOTE: the payload and response registers are reset as well, because they
  // drive outputs directly and every output must read 0 while rst is high.
  always_ff @(posedge clk1_50 or posedge rst) begin
    if (rst) begin
      r_ptr     <= IDX_W'(NUM_MASTERS - 1);
      r_win_idx <= '0;
      r_win_oh  <= '0;
      r_gnt     <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
    end else begin
      r_gnt <= '0;
      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            r_gnt     <= w_pick_oh;
            r_win_oh  <= w_pick_oh;
            r_win_idx <= w_pick_idx;
            r_we      <= bus.m_we[w_pick_idx];
            r_addr    <= bus.m_addr[w_pick_idx];
            r_wdata   <= bus.m_wdata[w_pick_idx];
          end
        end
        BUSY: begin
          if (w_ack) begin
            r_rdata <= r_we ? '0 : bus.s_rdata;
          end else if (w_timeout) begin
            r_rdata <= '0;
          end
        end
        RESP: begin
          r_ptr <= r_win_idx;
        end
        default: ;
      endcase
    end
  end

  // Everything below decodes registered state, so reset clears it at once.
  assign bus.m_gnt    = r_gnt;
  assign bus.m_rvalid = (r_state == RESP) ? r_win_oh : '0;
  assign bus.m_rdata  = r_rdata;
  assign bus.s_req    = (r_state == BUSY);
  assign bus.s_we     = r_we;
  assign bus.s_addr   = r_addr;
  assign bus.s_wdata  = r_wdata;
  assign bus.busy     = (r_state != IDLE);

endmodule

// File: tb/tb_sysbus_arb.sv
module tb_sysbus_arb;

  localparam int NM = 4;
  localparam int AW = 24;
  localparam int DW = 16;
  localparam int TO = 8;
`ifdef SYSBUS_TIMEOUT_EN
  localparam int SLOW_ACK = 6;
`else
  localparam int SLOW_ACK = 10;
`endif

  logic clk1_50 = 1'b0;
  logic rst     = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  sysbus_arb_if #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW)) bus ();

  sysbus_arb #(
    .NUM_MASTERS (NM),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk1_50 (clk1_50),
    .rst     (rst),
    .bus     (bus)
  );

  always #10 clk1_50 = ~clk1_50;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic nxt();
    @(posedge clk1_50);
    #1;
  endtask

  task automatic idle_inputs();
    bus.m_req   = '0;
    bus.m_we    = '0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    bus.s_ack   = 1'b0;
    bus.s_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    nxt();
    nxt();
    rst = 1'b0;
    nxt();
  endtask

  // Finish any transaction in flight; a stuck DUT is reported, not waited on.
  task automatic drain();
    int n = 0;
    bus.m_req = '0;
    bus.s_ack = 1'b1;
    while (bus.busy === 1'b1 && n < 10) begin
      nxt();
      n++;
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL drain_timeout busy=%b after %0d cycles, wanted 0", bus.busy, n);
    end
    bus.s_ack = 1'b0;
    nxt();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    nxt();
    nxt();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.s_req !== 1'b0) begin failures++; $display("FAIL reset_s_req got=%b exp=0", bus.s_req); end
    checks++; if (bus.m_gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", bus.m_gnt); end
    checks++; if (bus.m_rvalid !== 4'b0000) begin failures++; $display("FAIL reset_rvalid got=%b exp=0000", bus.m_rvalid); end
    checks++; if (bus.m_rdata !== 16'h0000) begin failures++; $display("FAIL reset_rdata got=%h exp=0000", bus.m_rdata); end
    checks++; if (bus.m_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.m_err); end
    checks++; if (bus.s_addr !== 24'h0) begin failures++; $display("FAIL reset_s_addr got=%h exp=000000", bus.s_addr); end
    rst = 1'b0;
    nxt();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_idle_no_req got=%b exp=0", bus.busy); end
  endtask

  // Master 0 read, ack one cycle after s_req rises: gnt at T+1, rvalid at T+3.
  task automatic test_single_read();
    bus.m_req     = 4'b0001;
    bus.m_we      = 4'b0000;
    bus.m_addr[0] = 24'h000123;
    nxt();  // T+1
    checks++; if (bus.m_gnt !== 4'b0001) begin failures++; $display("FAIL rd_gnt got=%b exp=0001", bus.m_gnt); end
    checks++; if ({bus.s_req, bus.s_we, bus.s_addr} !== {1'b1, 1'b0, 24'h000123})
      begin failures++; $display("FAIL rd_s_bus got=%b/%b/%h exp=1/0/000123", bus.s_req, bus.s_we, bus.s_addr); end
    bus.m_req = 4'b0000;
    nxt();  // T+2
    checks++; if (bus.m_gnt !== 4'b0000) begin failures++; $display("FAIL rd_gnt_one_cycle got=%b exp=0000", bus.m_gnt); end
    checks++; if (bus.s_req !== 1'b1) begin failures++; $display("FAIL rd_s_req_hold got=%b exp=1", bus.s_req); end
    bus.s_ack   = 1'b1;
    bus.s_rdata = 16'hBEEF;
    nxt();  // T+3
    checks++; if (bus.m_rvalid !== 4'b0001) begin failures++; $display("FAIL rd_rvalid got=%b exp=0001", bus.m_rvalid); end
    checks++; if (bus.m_rdata !== 16'hBEEF) begin failures++; $display("FAIL rd_rdata got=%h exp=beef", bus.m_rdata); end
    checks++; if (bus.m_err !== 1'b0) begin failures++; $display("FAIL rd_err got=%b exp=0", bus.m_err); end
    checks++; if (bus.s_req !== 1'b0) begin failures++; $display("FAIL rd_s_req_resp got=%b exp=0", bus.s_req); end
    bus.s_rdata = 16'h1111;  // ack stays high with no request: must be ignored
    nxt();  // T+4
    checks++; if (bus.m_rvalid !== 4'b0000) begin failures++; $display("FAIL rd_rvalid_pulse got=%b exp=0000", bus.m_rvalid); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rd_back_idle got=%b exp=0", bus.busy); end
    nxt();  // T+5
    checks++; if (bus.m_rdata !== 16'hBEEF) begin failures++; $display("FAIL rd_rdata_hold got=%h exp=beef", bus.m_rdata); end
    checks++; if ({bus.busy, bus.s_req} !== 2'b00) begin failures++; $display("FAIL rd_stray_ack got=%b exp=00", {bus.busy, bus.s_req}); end
    bus.s_ack = 1'b0;
    nxt();
  endtask

  // Reset in the 3rd BUSY cycle: immediate clear, no late rvalid, ptr restored.
  task automatic test_reset_mid();
    bool_check_rv: begin end
    bus.m_req     = 4'b0001;
    bus.m_addr[0] = 24'h000200;
    nxt();  // BUSY 1
    checks++; if (bus.m_gnt !== 4'b0001) begin failures++; $display("FAIL rm_gnt got=%b exp=0001", bus.m_gnt); end
    bus.m_req = 4'b0000;
    nxt();  // BUSY 2
    nxt();  // BUSY 3
    rst = 1'b1;
    #1;
    checks++; if (bus.s_req !== 1'b0) begin failures++; $display("FAIL rm_s_req_async got=%b exp=0", bus.s_req); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rm_busy_async got=%b exp=0", bus.busy); end
    checks++; if ({bus.m_rdata, bus.s_addr} !== 40'h0) begin failures++; $display("FAIL rm_outputs_zero got=%h/%h exp=0/0", bus.m_rdata, bus.s_addr); end
    bus.s_ack = 1'b1;
    nxt();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nxt();
      checks++; if (bus.m_rvalid !== 4'b0000) begin failures++; $display("FAIL rm_no_rvalid cyc=%0d got=%b exp=0000", i, bus.m_rvalid); end
    end
    bus.s_ack = 1'b0;
    bus.m_req = 4'b1100;
    nxt();
    checks++; if (bus.m_gnt !== 4'b0100) begin failures++; $display("FAIL rm_next_gnt got=%b exp=0100", bus.m_gnt); end
    drain();
  endtask

  // All four masters requesting with an immediate ack: gnts 3 cycles apart.
  task automatic test_round_robin();
    logic [3:0] exp_gnt [14];
    logic [3:0] exp_rv  [14];
    exp_gnt = '{4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0100,
                4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
    exp_rv  = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000,
                4'b0100, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0001};
    do_reset();
    bus.s_ack   = 1'b1;
    bus.s_rdata = 16'h7700;
    bus.m_req   = 4'b1111;
    for (int c = 1; c <= 14; c++) begin
      nxt();
      checks++; if (bus.m_gnt !== exp_gnt[c-1]) begin failures++; $display("FAIL rr_gnt cyc=%0d got=%b exp=%b", c, bus.m_gnt, exp_gnt[c-1]); end
      checks++; if (bus.m_rvalid !== exp_rv[c-1]) begin failures++; $display("FAIL rr_rvalid cyc=%0d got=%b exp=%b", c, bus.m_rvalid, exp_rv[c-1]); end
    end
    bus.m_req = 4'b0000;
    nxt();
    checks++; if (bus.m_rdata !== 16'h7700) begin failures++; $display("FAIL rr_rdata got=%h exp=7700", bus.m_rdata); end
    drain();
  endtask

  // Master 2 write with slow ack: payload stays put even after req/payload change.
  task automatic test_slow_write();
    bus.m_req      = 4'b0100;
    bus.m_we       = 4'b0100;
    bus.m_addr[1]  = 24'h111111;
    bus.m_addr[2]  = 24'h00ABCD;
    bus.m_wdata[2] = 16'h5A5A;
    bus.s_rdata    = 16'hFFFF;
    for (int k = 1; k <= SLOW_ACK + 1; k++) begin
      nxt();
      if (k == 1) begin
        checks++; if (bus.m_gnt !== 4'b0100) begin failures++; $display("FAIL wr_gnt got=%b exp=0100", bus.m_gnt); end
      end
      if (k == 2) begin
        bus.m_req      = 4'b0000;
        bus.m_we       = 4'b0000;
        bus.m_addr[2]  = 24'hFFFFFF;
        bus.m_wdata[2] = 16'h0000;
      end
      checks++;
      if ({bus.s_req, bus.s_we, bus.s_addr, bus.s_wdata} !== {1'b1, 1'b1, 24'h00ABCD, 16'h5A5A}) begin
        failures++;
        $display("FAIL wr_stable cyc=%0d got=%b/%b/%h/%h exp=1/1/00abcd/5a5a",
                 k, bus.s_req, bus.s_we, bus.s_addr, bus.s_wdata);
      end
      if (k == SLOW_ACK + 1) bus.s_ack = 1'b1;
    end
    nxt();
    checks++; if (bus.m_rvalid !== 4'b0100) begin failures++; $display("FAIL wr_rvalid got=%b exp=0100", bus.m_rvalid); end
    checks++; if (bus.m_rdata !== 16'h0000) begin failures++; $display("FAIL wr_rdata got=%h exp=0000", bus.m_rdata); end
    checks++; if (bus.m_err !== 1'b0) begin failures++; $display("FAIL wr_err got=%b exp=0", bus.m_err); end
    checks++; if (bus.s_req !== 1'b0) begin failures++; $display("FAIL wr_s_req_drop got=%b exp=0", bus.s_req); end
    bus.s_ack = 1'b0;
    nxt();
  endtask

`ifdef SYSBUS_TIMEOUT_EN
  // TIMEOUT_CYC=8: no ack aborts after 8 BUSY cycles; ack in cycle 8 wins.
  task automatic test_timeout();
    bus.m_we      = 4'b0000;
    bus.m_addr[1] = 24'h000042;
    bus.s_rdata   = 16'h1234;
    for (int pass = 0; pass < 2; pass++) begin
      bus.m_req = 4'b0010;
      for (int k = 1; k <= 8; k++) begin
        nxt();
        if (k == 1) begin
          checks++; if (bus.m_gnt !== 4'b0010) begin failures++; $display("FAIL to_gnt pass=%0d got=%b exp=0010", pass, bus.m_gnt); end
          bus.m_req = 4'b0000;
        end
        checks++; if (bus.s_req !== 1'b1) begin failures++; $display("FAIL to_s_req pass=%0d cyc=%0d got=%b exp=1", pass, k, bus.s_req); end
        if (pass == 1 && k == 8) bus.s_ack = 1'b1;
      end
      nxt();
      checks++; if (bus.s_req !== 1'b0) begin failures++; $display("FAIL to_s_req_drop pass=%0d got=%b exp=0", pass, bus.s_req); end
      checks++; if (bus.m_rvalid !== 4'b0010) begin failures++; $display("FAIL to_rvalid pass=%0d got=%b exp=0010", pass, bus.m_rvalid); end
      checks++; if (bus.m_err !== (pass == 0)) begin failures++; $display("FAIL to_err pass=%0d got=%b exp=%b", pass, bus.m_err, pass == 0); end
      checks++;
      if (bus.m_rdata !== ((pass == 0) ? 16'h0000 : 16'h1234)) begin
        failures++;
        $display("FAIL to_rdata pass=%0d got=%h exp=%h", pass, bus.m_rdata, (pass == 0) ? 16'h0000 : 16'h1234);
      end
      bus.s_ack = 1'b0;
      nxt();
    end
  endtask
`endif

  initial begin
    idle_inputs();
    test_reset();
    test_single_read();
    test_reset_mid();
    test_round_robin();
    test_slow_write();
`ifdef SYSBUS_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sysbus_arb.md
SYSBUS_ARB -- requirements
Module: sysbus_arb

Interface
REQ-001 The block SHALL take parameter NUM_MASTERS, default 4, the number of requesting masters (legal 2..8).
REQ-002 The block SHALL take parameter ADDR_W, default 24, the bus address width.
REQ-003 The block SHALL take parameter DATA_W, default 16, the bus data width.
REQ-004 The block SHALL take parameter TIMEOUT_CYC, default 255, the slave-ack timeout in cycles (legal 1..65535).
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-006 clk1_50  in  1  system clock, all logic on the rising edge.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 m_req  in  NUM_MASTERS  per-master transaction request.
REQ-009 m_we  in  NUM_MASTERS  per-master write (1) / read (0).
REQ-010 m_addr  in  NUM_MASTERS x ADDR_W  per-master address.
REQ-011 m_wdata  in  NUM_MASTERS x DATA_W  per-master write data.
REQ-012 m_gnt  out  NUM_MASTERS  one-hot one-cycle request-accepted pulse.
REQ-013 m_rvalid  out  NUM_MASTERS  one-hot one-cycle completion pulse.
REQ-014 m_rdata  out  DATA_W  shared read data, valid only with m_rvalid.
REQ-015 m_err  out  1  completion error flag, valid only with m_rvalid.
REQ-016 s_req, s_we  out  1 each  downstream request and direction.
REQ-017 s_addr, s_wdata  out  ADDR_W, DATA_W  downstream address and write data.
REQ-018 s_ack, s_rdata  in  1, DATA_W  downstream completion and read data.
REQ-019 busy  out  1  high in every state other than IDLE.

Function
REQ-020 The FSM SHALL have the states IDLE, BUSY and RESP, with one transaction in flight at most.
REQ-021 IDLE with any m_req high SHALL select a winner round-robin, searching upward from index ptr+1 and wrapping at NUM_MASTERS, then latch that master's we/addr/wdata and move to BUSY on the next edge.
REQ-022 In the first BUSY cycle m_gnt[winner] SHALL be 1 for exactly one cycle, and s_req SHALL be 1 from that cycle on with the latched payload on s_we/s_addr/s_wdata.
REQ-023 Masters SHALL hold req and payload stable until gnt; a req dropped after gnt SHALL NOT affect the transaction in flight.
REQ-024 BUSY SHALL hold s_req and the payload constant until s_ack; on s_ack the block SHALL capture s_rdata (reads) or 0 (writes) and go to RESP.
REQ-025 RESP SHALL pulse m_rvalid[winner] for one cycle with the captured m_rdata and the error flag, SHALL set ptr to winner, and SHALL return to IDLE.
REQ-026 With a single-cycle ack the minimum latency SHALL be 3 cycles (req sampled → rvalid), giving at most one transaction per 3 cycles.
REQ-027 s_ack SHALL be ignored outside BUSY; s_req SHALL be 0 outside BUSY.
REQ-028 Once back in IDLE, the m_rdata and m_err outputs SHALL hold their last value.

Reset
REQ-029 rst SHALL force state IDLE and ptr=NUM_MASTERS-1 (master 0 has first priority), and SHALL force all outputs to 0 at once, including mid-transaction; no pending rvalid is issued after reset.

Configuration
REQ-030 With SYSBUS_TIMEOUT_EN defined, a counter cleared on entry to BUSY SHALL count BUSY cycles without s_ack.
REQ-031 With SYSBUS_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYC the block SHALL drop s_req and go to RESP with m_err=1 and m_rdata=0.
REQ-032 With SYSBUS_TIMEOUT_EN defined, s_ack in the same cycle as the timeout SHALL win (normal completion, m_err=0).
REQ-033 Without SYSBUS_TIMEOUT_EN, BUSY SHALL wait indefinitely, m_err SHALL be tied to 0, and no counter SHALL be synthesised.

Structure
REQ-034 The shared package pkg SHALL hold the enum sysbus_state_t {IDLE, BUSY, RESP} and the constants SYSBUS_ADDR_W=24 and SYSBUS_DATA_W=16 used as parameter defaults.
REQ-035 The round-robin pick (m_req, ptr → one-hot winner plus index) SHALL be the combinational sub-module sysbus_rr_pick.

Verification
REQ-036 After reset, m_req=4'b0001, read of 0x000123, s_ack one cycle after s_req with s_rdata=0xBEEF → gnt[0] at T+1, rvalid[0] at T+3, m_rdata=0xBEEF, m_err=0.
REQ-037 m_req=4'b1111 held continuously → grant order 0,1,2,3,0, each gnt exactly 3 cycles apart.
REQ-038 Master 2 write of 0x00ABCD/0x5A5A with s_ack delayed 10 cycles → s_addr/s_wdata/s_we stable for all 11 s_req cycles, rvalid[2] with m_rdata=0.
REQ-039 SYSBUS_TIMEOUT_EN, TIMEOUT_CYC=8, s_ack never asserted → s_req drops after 8 BUSY cycles, rvalid with m_err=1, m_rdata=0; repeated with s_ack at count 8 → m_err=0.
REQ-040 rst asserted at the 3rd BUSY cycle → s_req=0 combinationally, no rvalid after release, and the next grant with m_req=4'b1100 goes to master 2.
